// File: rtl/ipg_pkg.sv
// Shared definitions for the PHY inter-packet-gap request/response channel:
// opcodes, chunk field positions and field extract/pack helpers.
package ipg_pkg;

  typedef enum logic [7:0] {
    IPG_OP_REQ  = 8'h5A,
    IPG_OP_RESP = 8'hA5
  } ipg_op_e;

  typedef logic [63:0] ipg_chunk_t;

  localparam int IPG_OP_MSB  = 63;
  localparam int IPG_OP_LSB  = 56;
  localparam int IPG_TAG_MSB = 55;
  localparam int IPG_TAG_LSB = 48;
  localparam int IPG_PAY_MSB = 47;
  localparam int IPG_PAY_LSB = 0;

  function automatic logic [7:0] ipg_opcode(input ipg_chunk_t chunk);
    return chunk[IPG_OP_MSB:IPG_OP_LSB];
  endfunction

  function automatic logic [7:0] ipg_tag(input ipg_chunk_t chunk);
    return chunk[IPG_TAG_MSB:IPG_TAG_LSB];
  endfunction

  function automatic logic [47:0] ipg_payload(input ipg_chunk_t chunk);
    return chunk[IPG_PAY_MSB:IPG_PAY_LSB];
  endfunction

  function automatic ipg_chunk_t ipg_pack(input logic [7:0] op, input logic [7:0] tag,
                                          input logic [47:0] payload);
    return {op, tag, payload};
  endfunction

endpackage

// File: rtl/ipg_scoreboard.sv
// Per-tag in-flight tracking: a busy bit and the 16-bit issue timestamp for each tag,
// with one set port, two clear ports (response match, timeout scan) and two ts read ports.
module ipg_scoreboard
  import ipg_pkg::*;
#(
  parameter int TAG_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_set,
  input  logic [TAG_WIDTH-1:0]    i_set_tag,
  input  logic [15:0]             i_set_ts,
  input  logic                    i_mclr,
  input  logic [TAG_WIDTH-1:0]    i_mclr_tag,
  input  logic                    i_sclr,
  input  logic [TAG_WIDTH-1:0]    i_sclr_tag,
  input  logic [TAG_WIDTH-1:0]    i_rd_tag_a,
  input  logic [TAG_WIDTH-1:0]    i_rd_tag_b,
  output logic [2**TAG_WIDTH-1:0] o_busy,
  output logic [15:0]             o_ts_a,
  output logic [15:0]             o_ts_b
);
  localparam int NSLOT = 2 ** TAG_WIDTH;

  logic [NSLOT-1:0] r_busy;
  logic [15:0]      r_ts [NSLOT];

  // Slot state; the engine only sets free slots and only clears busy ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        r_ts[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (i_set && (i_set_tag == TAG_WIDTH'(i))) begin
          r_busy[i] <= 1'b1;
          r_ts[i]   <= i_set_ts;
        end else if ((i_mclr && (i_mclr_tag == TAG_WIDTH'(i))) ||
                     (i_sclr && (i_sclr_tag == TAG_WIDTH'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_ts_a = r_ts[i_rd_tag_a];
  assign o_ts_b = r_ts[i_rd_tag_b];

endmodule

// File: rtl/ipg_req_engine.sv
// Periodic tagged request issuer for the PHY IPG channel; matches recovered responses
// to in-flight tags and reports latency, timeouts and unexpected responses.
module ipg_req_engine
  import ipg_pkg::*;
#(
  parameter int          TAG_WIDTH      = 4,
  parameter int          PERIOD         = 256,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [47:0] ADDR_BASE      = 48'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic [63:0]        ipg_req_chunk,
  output logic               reqq_write,
  input  logic [63:0]        ipg_rresp_chunk,
  output logic [31:0]        req_count,
  output logic [31:0]        resp_count,
  output logic [15:0]        timeout_count,
  output logic [15:0]        last_latency,
  output logic [TAG_WIDTH:0] outstanding,
  output logic               err_unexpected
);
  localparam int NSLOT = 2 ** TAG_WIDTH;
  localparam int PW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [15:0]          r_now;
  logic [PW-1:0]        r_period;
  logic [TAG_WIDTH-1:0] r_tag_ptr;
  logic [TAG_WIDTH-1:0] r_scan_ptr;
  ipg_chunk_t           r_resp;
  ipg_chunk_t           r_resp_prev;

  logic [NSLOT-1:0]     w_busy;
  logic [15:0]          w_ts_scan;
  logic [15:0]          w_ts_match;
  logic                 w_issue;
  logic [7:0]           w_resp_tag;
  logic [TAG_WIDTH-1:0] w_match_tag;
  logic                 w_resp_new;
  logic                 w_tag_in_range;
  logic                 w_match;
  logic                 w_unexp;
  logic [15:0]          w_scan_age;
  logic                 w_scan_expire;
  logic [15:0]          w_latency;
  logic [TAG_WIDTH:0]   w_popcnt;

  assign w_issue        = enable && (r_period == PW'(PERIOD - 1)) && !w_busy[r_tag_ptr];

  // The PHY holds its last recovered chunk, so only a changed RESP chunk is a new response.
  assign w_resp_tag     = ipg_tag(r_resp);
  assign w_match_tag    = w_resp_tag[TAG_WIDTH-1:0];
  assign w_resp_new     = (ipg_opcode(r_resp) == IPG_OP_RESP) && (r_resp != r_resp_prev);
  assign w_tag_in_range = ((w_resp_tag >> TAG_WIDTH) == 8'd0);
  assign w_match        = w_resp_new && w_tag_in_range && w_busy[w_match_tag];
  assign w_unexp        = w_resp_new && !(w_tag_in_range && w_busy[w_match_tag]);
  assign w_latency      = r_now - w_ts_match - 16'd1;

  // A response landing on the slot being expired takes priority over the timeout.
  assign w_scan_age     = r_now - w_ts_scan;
  assign w_scan_expire  = w_busy[r_scan_ptr] && (w_scan_age >= 16'(TIMEOUT_CYCLES)) &&
                          !(w_match && (w_match_tag == r_scan_ptr));

  // Number of tags currently in flight.
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < NSLOT; i++) begin
      w_popcnt = w_popcnt + (TAG_WIDTH + 1)'(w_busy[i]);
    end
  end

  ipg_scoreboard #(
    .TAG_WIDTH (TAG_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set      (w_issue),
    .i_set_tag  (r_tag_ptr),
    .i_set_ts   (r_now),
    .i_mclr     (w_match),
    .i_mclr_tag (w_match_tag),
    .i_sclr     (w_scan_expire),
    .i_sclr_tag (r_scan_ptr),
    .i_rd_tag_a (r_scan_ptr),
    .i_rd_tag_b (w_match_tag),
    .o_busy     (w_busy),
    .o_ts_a     (w_ts_scan),
    .o_ts_b     (w_ts_match)
  );

  // Timebase, issue path, response capture and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_now          <= 16'd0;
      r_period       <= '0;
      r_tag_ptr      <= '0;
      r_scan_ptr     <= '0;
      r_resp         <= 64'd0;
      r_resp_prev    <= 64'd0;
      ipg_req_chunk  <= 64'd0;
      reqq_write     <= 1'b0;
      req_count      <= 32'd0;
      resp_count     <= 32'd0;
      timeout_count  <= 16'd0;
      last_latency   <= 16'd0;
      outstanding    <= '0;
      err_unexpected <= 1'b0;
    end else begin
      r_now       <= r_now + 16'd1;
      r_period    <= (r_period == PW'(PERIOD - 1)) ? '0 : r_period + PW'(1);
      r_scan_ptr  <= r_scan_ptr + TAG_WIDTH'(1);
      r_resp      <= ipg_rresp_chunk;
      r_resp_prev <= r_resp;
      reqq_write  <= w_issue;
      if (w_issue) begin
        ipg_req_chunk <= ipg_pack(IPG_OP_REQ, 8'(r_tag_ptr), ADDR_BASE + 48'(req_count));
        r_tag_ptr     <= r_tag_ptr + TAG_WIDTH'(1);
        req_count     <= req_count + 32'd1;
      end
      if (w_match) begin
        resp_count   <= resp_count + 32'd1;
        last_latency <= w_latency;
      end
      if (w_scan_expire && (timeout_count != 16'hFFFF)) begin
        timeout_count <= timeout_count + 16'd1;
      end
      err_unexpected <= w_unexp;
      outstanding    <= w_popcnt;
    end
  end

endmodule

// File: tb/tb_ipg_req_engine.sv
// Directed bench for ipg_req_engine: issue cadence, timeouts and slot reuse, async reset,
// loopback latency, stray/held/out-of-range responses, response-vs-timeout race, enable gating.
module tb_ipg_req_engine;
  localparam int          TW   = 4;
  localparam logic [47:0] BASE = 48'hFFFF_FFFF_FFFE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [63:0] ipg_req_chunk;
  logic        reqq_write;
  logic [63:0] ipg_rresp_chunk;
  logic [31:0] req_count;
  logic [31:0] resp_count;
  logic [15:0] timeout_count;
  logic [15:0] last_latency;
  logic [TW:0] outstanding;
  logic        err_unexpected;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulses   = 0;
  int c        = 0;

  ipg_req_engine #(
    .TAG_WIDTH      (TW),
    .PERIOD         (256),
    .TIMEOUT_CYCLES (4096),
    .ADDR_BASE      (BASE)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .ipg_req_chunk   (ipg_req_chunk),
    .reqq_write      (reqq_write),
    .ipg_rresp_chunk (ipg_rresp_chunk),
    .req_count       (req_count),
    .resp_count      (resp_count),
    .timeout_count   (timeout_count),
    .last_latency    (last_latency),
    .outstanding     (outstanding),
    .err_unexpected  (err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  function automatic logic [63:0] req_chunk(input int tag, input int n);
    return {8'h5A, 8'(tag), BASE + 48'(n)};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_reqq"},    64'(reqq_write),     64'd0);
    chk({tag, "_chunk"},   ipg_req_chunk,       64'd0);
    chk({tag, "_reqcnt"},  64'(req_count),      64'd0);
    chk({tag, "_respcnt"}, 64'(resp_count),     64'd0);
    chk({tag, "_tocnt"},   64'(timeout_count),  64'd0);
    chk({tag, "_lat"},     64'(last_latency),   64'd0);
    chk({tag, "_outst"},   64'(outstanding),    64'd0);
    chk({tag, "_err"},     64'(err_unexpected), 64'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    enable          = 1'b1;
    ipg_rresp_chunk = 64'd0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    cyc   = 0;

    // Issue cadence, saturation of the tag space, timeout retirement and slot reuse.
    wait_to(255);  chk("a_pre_issue", 64'(reqq_write), 64'd0);
    wait_to(256);  chk("a_issue0", 64'(reqq_write), 64'd1);
                   chk("a_chunk0", ipg_req_chunk, req_chunk(0, 0));
    wait_to(257);  chk("a_pulse_end", 64'(reqq_write), 64'd0);
                   chk("a_reqcnt1", 64'(req_count), 64'd1);
                   chk("a_outst1", 64'(outstanding), 64'd1);
    wait_to(300);  chk("a_chunk_held", ipg_req_chunk, req_chunk(0, 0));
    wait_to(512);  chk("a_chunk1", ipg_req_chunk, req_chunk(1, 1));
    wait_to(4096); chk("a_issue15", 64'(reqq_write), 64'd1);
                   chk("a_chunk15", ipg_req_chunk, req_chunk(15, 15));
    wait_to(4097); chk("a_outst16", 64'(outstanding), 64'd16);
                   chk("a_reqcnt16", 64'(req_count), 64'd16);
    wait_to(4352); chk("a_skip", 64'(reqq_write), 64'd0);
                   chk("a_no_early_to", 64'(timeout_count), 64'd0);
    wait_to(4353); chk("a_to1", 64'(timeout_count), 64'd1);
                   chk("a_reqcnt_skip", 64'(req_count), 64'd16);
    wait_to(4354); chk("a_outst15", 64'(outstanding), 64'd15);
    wait_to(4608); chk("a_reuse", 64'(reqq_write), 64'd1);
                   chk("a_chunk_reuse", ipg_req_chunk, req_chunk(0, 16));
    wait_to(4609); chk("a_to1_hold", 64'(timeout_count), 64'd1);
    wait_to(4610); chk("a_to2", 64'(timeout_count), 64'd2);
                   chk("a_outst_pre_rst", 64'(outstanding), 64'd16);

    // Asynchronous reset in the middle of a cycle clears everything at once.
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // A response for a tag that was in flight before reset is now unexpected.
    wait_to(2);    ipg_rresp_chunk = {8'hA5, 8'h05, 48'h0000_0000_DEAD};
    wait_to(3);    chk("b_err_lat", 64'(err_unexpected), 64'd0);
    wait_to(4);    chk("b_stale_err", 64'(err_unexpected), 64'd1);
                   chk("b_stale_resp", 64'(resp_count), 64'd0);
    wait_to(5);    chk("b_err_end", 64'(err_unexpected), 64'd0);
    wait_to(255);  chk("b_pre_issue", 64'(reqq_write), 64'd0);

    // Loopback: each response appears on the input 40 cycles after its timestamp.
    for (int k = 0; k < 3; k++) begin
      c = 256 * (k + 1);
      wait_to(c);      chk("c_issue", 64'(reqq_write), 64'd1);
                       chk("c_chunk", ipg_req_chunk, req_chunk(k, k));
      wait_to(c + 10); chk("c_outst1", 64'(outstanding), 64'd1);
      wait_to(c + 39); ipg_rresp_chunk = {8'hA5, 8'(k), BASE + 48'(k)};
      wait_to(c + 41); chk("c_latency", 64'(last_latency), 64'd40);
                       chk("c_respcnt", 64'(resp_count), 64'(k + 1));
                       chk("c_reqcnt", 64'(req_count), 64'(k + 1));
                       chk("c_no_err", 64'(err_unexpected), 64'd0);
      wait_to(c + 43); chk("c_outst0", 64'(outstanding), 64'd0);
    end

    // Stray response for free tag 7, held for several cycles: one pulse only.
    wait_to(900);  ipg_rresp_chunk = {8'hA5, 8'h07, 48'h0000_0000_0077};
    pulses = 0;
    while (cyc < 912) begin
      step();
      if (err_unexpected) pulses++;
      if (cyc == 902) chk("d_err_pulse", 64'(err_unexpected), 64'd1);
    end
    chk("d_pulse_count", 64'(pulses), 64'd1);
    chk("d_respcnt", 64'(resp_count), 64'd3);
    chk("d_tocnt", 64'(timeout_count), 64'd0);
    wait_to(1030); chk("d_outst_tag3", 64'(outstanding), 64'd1);

    // Tag outside the tag space (low bits alias busy tag 3) and a non-RESP opcode.
    wait_to(1100); ipg_rresp_chunk = {8'hA5, 8'h13, 48'h0000_0000_0013};
    wait_to(1102); chk("e_range_err", 64'(err_unexpected), 64'd1);
                   chk("e_range_resp", 64'(resp_count), 64'd3);
    wait_to(1120); ipg_rresp_chunk = {8'h5A, 8'h03, 48'h0000_0000_0003};
    wait_to(1122); chk("e_op_err", 64'(err_unexpected), 64'd0);
                   chk("e_op_resp", 64'(resp_count), 64'd3);
    wait_to(1130); ipg_rresp_chunk = 64'd0;

    // Tag 3 (ts 1023) is first seen expired by the scan at cycle 5123; respond then.
    wait_to(5122); chk("f_pre_to", 64'(timeout_count), 64'd0);
                   ipg_rresp_chunk = {8'hA5, 8'h03, 48'h0000_0000_0003};
    wait_to(5124); chk("f_respcnt", 64'(resp_count), 64'd4);
                   chk("f_tocnt", 64'(timeout_count), 64'd0);
                   chk("f_latency", 64'(last_latency), 64'd4099);
                   chk("f_reqcnt", 64'(req_count), 64'd19);

    // Disabled: no issue at the next attempt, but retirement continues.
    wait_to(5130); enable = 1'b0;
    wait_to(5376); chk("g_no_issue", 64'(reqq_write), 64'd0);
    wait_to(5377); chk("g_reqcnt", 64'(req_count), 64'd19);
    wait_to(5380); chk("g_to_pre", 64'(timeout_count), 64'd0);
    wait_to(5381); chk("g_to_tag4", 64'(timeout_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
